// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NUM_REQ requesters.
// Define ALU_ARB_STATS_EN to add the stat_ops / stat_busy counters.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_data
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]              stat_ops,
  output logic [31:0]              stat_busy
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        sel_q, sel_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  resp_data_q, resp_data_d;
  logic              resp_valid_q, resp_valid_d;

  logic [WIDTH-1:0]  a_arr   [NUM_REQ];
  logic [WIDTH-1:0]  b_arr   [NUM_REQ];
  logic [2:0]        sel_arr [NUM_REQ];

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_accept;
  logic [ID_W:0]     cand_sum;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i]   = req_a[i*WIDTH +: WIDTH];
      b_arr[i]   = req_b[i*WIDTH +: WIDTH];
      sel_arr[i] = req_sel[i*3 +: 3];
    end
  end

  // Scan from rr_ptr upward, wrapping modulo NUM_REQ; the first valid requester wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand_sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[ID_W-1:0];
      end
    end
  end

  // No handshake while reset is asserted, so no requester believes it was accepted.
  assign grant_accept = (state_q == IDLE) && grant_found && !rst;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    id_d         = id_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (grant_accept) begin
          req_ready[grant_idx] = 1'b1;
          a_d      = a_arr[grant_idx];
          b_d      = b_arr[grant_idx];
          sel_d    = sel_arr[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        resp_data_d  = alu_out;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      id_q         <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      id_q         <= id_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // ALU inputs hold the last latched operands outside EXEC instead of returning to zero.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_busy_q, stat_busy_d;

  // An op occupies the ALU path from its accept cycle through its RESP handshake.
  always_comb begin
    stat_ops_d  = stat_ops_q + ((resp_valid_q && resp_ready) ? 32'd1 : 32'd0);
    stat_busy_d = stat_busy_q + ((state_q != IDLE || grant_accept) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q  <= '0;
      stat_busy_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_busy_q <= stat_busy_d;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_busy = stat_busy_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed table, multi-cycle corner cases,
// and randomized ops checked against a round-robin reference model.
module tb_alu_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N*3-1:0]  req_sel;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [2:0]      alu_sel;
  logic [W-1:0]    alu_out;
  logic            resp_valid;
  logic            resp_ready;
  logic [IW-1:0]   resp_id;
  logic [W-1:0]    resp_data;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]     stat_ops;
  logic [31:0]     stat_busy;
`endif

  logic [W-1:0]    ra [N];
  logic [W-1:0]    rb [N];
  logic [2:0]      rs [N];

  int n_cmp = 0;
  int n_err = 0;
  int ref_ptr = 0;

  typedef struct {
    logic [N-1:0] mask;
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  int           gid   [$];
  int           gcyc  [$];
  int           rid   [$];
  logic [W-1:0] rdata [$];
  int           multi;
  int           late_resp;

  alu_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data)
`ifdef ALU_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_busy(stat_busy)
`endif
  );

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*W +: W]   = ra[g];
    assign req_b[g*W +: W]   = rb[g];
    assign req_sel[g*3 +: 3] = rs[g];
  end

  // Behavioural stand-in for the shared ALU.
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] s);
    case (s)
      3'd0, 3'd1: return a + b;
      3'd2, 3'd3: return a - b;
      3'd4:       return a & b;
      3'd5:       return a | b;
      3'd6:       return $signed(a) >>> b[4:0];
      default:    return a >> b[4:0];
    endcase
  endfunction

  assign alu_out = alu_model(alu_a, alu_b, alu_sel);

  function automatic int ref_grant(input logic [N-1:0] mask, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (mask[j[1:0]]) return j;
    end
    return -1;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    ref_ptr = 0;
  endtask

  // One op starting in IDLE: grant, EXEC, RESP (optionally stalled), handshake.
  task automatic run_op(input logic [N-1:0] mask, input int exp_idx, input logic [W-1:0] exp_data,
                        input int stall, input string nm);
    int           waited;
    logic [N-1:0] exp_ready;
    exp_ready  = N'(1) << exp_idx;
    req_valid  = mask;
    resp_ready = (stall == 0);
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({nm, " grant latency"}, W'(waited), W'(0));
    check({nm, " req_ready"}, W'(req_ready), W'(exp_ready));
    @(negedge clk);
    req_valid = '0;
    #1;
    check({nm, " exec alu_a"}, alu_a, ra[exp_idx]);
    check({nm, " exec alu_b"}, alu_b, rb[exp_idx]);
    check({nm, " exec alu_sel"}, W'(alu_sel), W'(rs[exp_idx]));
    check({nm, " exec resp_valid"}, W'(resp_valid), W'(0));
    @(negedge clk);
    #1;
    for (int s = 0; s < stall; s++) begin
      check({nm, " stall resp_valid"}, W'(resp_valid), W'(1));
      check({nm, " stall resp_data"}, resp_data, exp_data);
      check({nm, " stall req_ready"}, W'(req_ready), W'(0));
      req_valid = ~exp_ready;
      @(negedge clk);
      #1;
    end
    check({nm, " resp_valid"}, W'(resp_valid), W'(1));
    check({nm, " resp_data"}, resp_data, exp_data);
    check({nm, " resp_id"}, W'(resp_id), W'(exp_idx));
    check({nm, " resp req_ready"}, W'(req_ready), W'(0));
    req_valid  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    ref_ptr = (exp_idx + 1) % N;
  endtask

  initial begin
    vecs[0] = '{4'b0010, 1, 32'd5,          32'd7,          3'd2, 32'hFFFF_FFFE};
    vecs[1] = '{4'b0100, 2, 32'hFFFF_FFFE,  32'd1,          3'd3, 32'hFFFF_FFFD};
    vecs[2] = '{4'b1000, 3, 32'h0000_F0F0,  32'h0000_FF00,  3'd4, 32'h0000_F000};
    vecs[3] = '{4'b0001, 0, 32'h0000_00F0,  32'h0000_000F,  3'd5, 32'h0000_00FF};
    vecs[4] = '{4'b0010, 1, 32'h8000_0000,  32'd4,          3'd6, 32'hF800_0000};
    vecs[5] = '{4'b0100, 2, 32'h8000_0000,  32'd4,          3'd7, 32'h0800_0000};
    vecs[6] = '{4'b1000, 3, 32'h7FFF_FFFF,  32'd1,          3'd0, 32'h8000_0000};
    vecs[7] = '{4'b0001, 0, 32'hFFFF_FFFF,  32'd1,          3'd1, 32'h0000_0000};

    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rb[i] = '0; rs[i] = '0;
    end
    reset_dut();
    #1;
    check("reset req_ready", W'(req_ready), W'(0));
    check("reset resp_valid", W'(resp_valid), W'(0));
    check("reset resp_id", W'(resp_id), W'(0));
    check("reset resp_data", resp_data, W'(0));
    check("reset alu_a", alu_a, W'(0));
    check("reset alu_b", alu_b, W'(0));
    check("reset alu_sel", W'(alu_sel), W'(0));
    @(negedge clk);

    // Basic signed add from requester 0.
    ra[0] = 32'd10; rb[0] = 32'hFFFF_FFFE; rs[0] = 3'd0;
    run_op(4'b0001, 0, 32'd8, 0, "t1");

    foreach (vecs[v]) begin
      ra[vecs[v].idx] = vecs[v].a;
      rb[vecs[v].idx] = vecs[v].b;
      rs[vecs[v].idx] = vecs[v].sel;
      run_op(vecs[v].mask, vecs[v].idx, vecs[v].exp, 0, $sformatf("vec%0d", v));
    end

    // All requesters continuously valid: rotation and spacing.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      ra[i] = W'(i + 1); rb[i] = W'(i); rs[i] = 3'd0;
    end
    req_valid = 4'hF;
    multi     = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if ($countones(req_ready) > 1) multi++;
      if (req_ready != '0) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) gid.push_back(k);
        gcyc.push_back(c);
      end
      if (resp_valid) begin
        rid.push_back(int'(resp_id));
        rdata.push_back(resp_data);
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("t2 onehot violations", W'(multi), W'(0));
    check("t2 grant count", W'(gid.size()), W'(5));
    check("t2 resp count", W'(rid.size()), W'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < gid.size()) check($sformatf("t2 grant%0d id", k), W'(gid[k]), W'(k % N));
      if (k > 0 && k < gcyc.size())
        check($sformatf("t2 grant%0d spacing", k), W'(gcyc[k] - gcyc[k-1]), W'(3));
      if (k < rid.size()) begin
        check($sformatf("t2 resp%0d id", k), W'(rid[k]), W'(k % N));
        check($sformatf("t2 resp%0d data", k), rdata[k], W'(2 * (k % N) + 1));
      end
    end
    @(negedge clk);
    ref_ptr = 1;

    // Backpressure on the response for five cycles.
    ra[2] = 32'hFFFF_FFFE; rb[2] = 32'd1; rs[2] = 3'd3;
    run_op(4'b0100, 2, 32'hFFFF_FFFD, 5, "t3");

    // Reset during EXEC drops the op and clears the pointer.
    ra[1] = 32'd4; rb[1] = 32'd1; rs[1] = 3'd7;
    req_valid = 4'b0010;
    #1;
    check("t4 grant", W'(req_ready), W'(4'b0010));
    @(negedge clk);
    req_valid = 4'b0010;
    rst       = 1'b1;
    #1;
    check("t4 ready during rst", W'(req_ready), W'(0));
    @(negedge clk);
    #1;
    check("t4 resp_valid", W'(resp_valid), W'(0));
    check("t4 req_ready", W'(req_ready), W'(0));
    check("t4 resp_data", resp_data, W'(0));
    check("t4 resp_id", W'(resp_id), W'(0));
    check("t4 alu_a", alu_a, W'(0));
    check("t4 alu_sel", W'(alu_sel), W'(0));
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    late_resp = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (resp_valid) late_resp++;
      @(negedge clk);
    end
    check("t4 dropped op responded", W'(late_resp), W'(0));
    ref_ptr = 0;
    ra[3] = 32'd0; rb[3] = 32'd1; rs[3] = 3'd5;
    run_op(4'b1010, 1, 32'd2, 0, "t4 ptr0");
    run_op(4'b1000, 3, 32'd1, 0, "t4 req3");

    // Pointer wrap from 3 back to 0.
    run_op(4'b0100, 2, 32'hFFFF_FFFD, 0, "t5 setup");
    ra[0] = 32'd1; rb[0] = 32'hFFFF_FFFF; rs[0] = 3'd1;
    run_op(4'b0001, 0, 32'd0, 0, "t5 wrap");
    run_op(4'b0011, 1, 32'd2, 0, "t5 ptr1");

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] mask;
      int           g;
      if ($urandom_range(0, 4) == 0) begin
        req_valid = '0;
        #1;
        check("rand idle req_ready", W'(req_ready), W'(0));
        @(negedge clk);
      end
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        ra[i] = $urandom;
        rb[i] = $urandom;
        rs[i] = 3'($urandom_range(0, 7));
      end
      g = ref_grant(mask, ref_ptr);
      run_op(mask, g, alu_model(ra[g], rb[g], rs[g]), $urandom_range(0, 3),
             $sformatf("rand%0d", it));
    end

`ifdef ALU_ARB_STATS_EN
    reset_dut();
    #1;
    check("stat_ops reset", stat_ops, 32'd0);
    check("stat_busy reset", stat_busy, 32'd0);
    @(negedge clk);
    ra[0] = 32'd3; rb[0] = 32'd4; rs[0] = 3'd0;
    for (int k = 0; k < 3; k++) run_op(4'b0001, 0, 32'd7, 0, $sformatf("stat%0d", k));
    #1;
    check("stat_ops", stat_ops, 32'd3);
    check("stat_busy", stat_busy, 32'd9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
